// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. It owns the fetch PC, issues one-word reads to the
// instruction memory, and buffers each returned word together with its byte PC
// in a small FIFO. The FIFO head is offered to decode. A redirect flushes the
// FIFO, drops any read still in flight, and restarts fetch at the target.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   imem_re_o      imem read enable (issue this cycle)
//   imem_raddr_o   imem word address = fetch_pc[ADDRWIDTH+1:2]
//   imem_rdata_i   imem read data, valid one cycle after imem_re_o
//   redirect_i     redirect request (branch / jump)
//   redirect_pc_i  redirect target byte address (low two bits ignored)
//   instr_valid_o  FIFO head valid
//   instr_ready_i  decode accepts the head
//   instr_o        head instruction
//   pc_o           byte PC of the head instruction
//
// Handshake: the head transfers on every rising edge where instr_valid_o and
// instr_ready_i are both high. While instr_valid_o is high and instr_ready_i is
// low, instr_o and pc_o stay stable until a transfer or a redirect. instr_valid_o
// never depends combinationally on instr_ready_i.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                   DATAWIDTH = 32,
    parameter int                   ADDRWIDTH = 12,
    parameter int                   DEPTH     = 2,
    parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 imem_re_o,
    output logic [ADDRWIDTH-1:0] imem_raddr_o,
    input  logic [DATAWIDTH-1:0] imem_rdata_i,
    input  logic                 redirect_i,
    input  logic [DATAWIDTH-1:0] redirect_pc_i,
    output logic                 instr_valid_o,
    input  logic                 instr_ready_i,
    output logic [DATAWIDTH-1:0] instr_o,
    output logic [DATAWIDTH-1:0] pc_o
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [CW1-1:0] DEPTH_W  = CW1'(DEPTH);
    localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

    // Fetch-side state
    logic [DATAWIDTH-1:0] fetch_pc;
    logic                 inflight;
    logic [DATAWIDTH-1:0] inflight_pc;

    // Instruction buffer
    logic [DATAWIDTH-1:0] fifo_pc    [DEPTH];
    logic [DATAWIDTH-1:0] fifo_instr [DEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [CW-1:0]        count;

    logic                 pop;
    logic                 push;
    logic                 issue;
    logic [CW1-1:0]       credit_used;

    // The target's low two bits are dropped on purpose (targets are aligned).
    logic                 unused_redirect_bits;
    assign unused_redirect_bits = &{1'b0, redirect_pc_i[1:0]};

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign instr_valid_o = (count != '0);
    assign instr_o       = fifo_instr[rd_ptr];
    assign pc_o          = fifo_pc[rd_ptr];

    assign pop  = instr_valid_o && instr_ready_i;
    assign push = inflight && !redirect_i;

    // Credit rule: every outstanding read already owns a FIFO slot, and a slot
    // freed by this cycle's pop may be reused immediately. pop implies count>=1,
    // so the subtraction cannot underflow.
    assign credit_used = {1'b0, count} + CW1'(inflight) - CW1'(pop);
    assign issue       = rst_i && !redirect_i && (credit_used < DEPTH_W);

    assign imem_re_o    = issue;
    assign imem_raddr_o = fetch_pc[ADDRWIDTH+1:2];

    // Fetch PC and in-flight tracking
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc    <= {RESET_PC[DATAWIDTH-1:2], 2'b00};
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[DATAWIDTH-1:2], 2'b00};
            inflight <= 1'b0;
        end else if (issue) begin
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + DATAWIDTH'(4);
        end else begin
            // Any outstanding read returns this cycle and is pushed now.
            inflight <= 1'b0;
        end
    end

    // Instruction FIFO. A redirect empties it; a pop in the same cycle is
    // subsumed by the flush.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= inflight_pc;
                fifo_instr[wr_ptr] <= imem_rdata_i;
                wr_ptr             <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The issue credit rule guarantees a free slot for every response.
    assert property (@(posedge clk_i) disable iff (!rst_i)
                     !(push && !pop && (count == DEPTH_C)));

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed and randomized bench for fetch_unit (DEPTH = 2, RESET_PC = 0).
// The reference model is the architectural view of fetch: after reset or a
// redirect to T, decode must accept T, T+4, T+8, ... in order, each paired with
// the imem word at that address. Expected PCs live in exp_q; expected
// instructions come from the bench's own imem image.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          DW       = 32;
    localparam int          AW       = 12;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          imem_re_o;
    logic [AW-1:0] imem_raddr_o;
    logic [DW-1:0] imem_rdata_i;
    logic          redirect_i;
    logic [DW-1:0] redirect_pc_i;
    logic          instr_valid_o;
    logic          instr_ready_i;
    logic [DW-1:0] instr_o;
    logic [DW-1:0] pc_o;

    fetch_unit #(
        .DATAWIDTH (DW),
        .ADDRWIDTH (AW),
        .DEPTH     (DEPTH),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_re_o     (imem_re_o),
        .imem_raddr_o  (imem_raddr_o),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- imem model ----------------
    logic [DW-1:0] mem [4096];

    // Data appears one cycle after the read; a junk value otherwise so that a
    // spurious push is visible.
    always @(posedge clk_i)
        imem_rdata_i <= imem_re_o ? mem[imem_raddr_o] : 32'hDEAD_BEEF;

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_pops   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Expected accepted-PC stream starts at the aligned target.
    task automatic seed(input logic [DW-1:0] target);
        logic [DW-1:0] t;
        t = {target[DW-1:2], 2'b00};
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(t + DW'(4 * i));
    endtask

    // Inputs are set before the call (at a falling edge); this settles,
    // scores any handshake of this cycle, and advances to the next falling edge.
    task automatic step();
        logic [DW-1:0] e;
        #1;
        if (rst_i && instr_valid_o && instr_ready_i) begin
            e = exp_q.pop_front();
            exp_q.push_back(e + DW'(16));
            check("hs_pc", pc_o, e);
            check("hs_instr", instr_o, mem[e[13:2]]);
            n_pops++;
        end
        if (rst_i && redirect_i) seed(redirect_pc_i);
        @(negedge clk_i);
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int i;
        i = 0;
        #1;
        while (!instr_valid_o && i < max_cycles) begin
            step();
            #1;
            i++;
        end
        check(tag, DW'(instr_valid_o), 32'd1);
    endtask

    task automatic do_reset();
        rst_i      = 1'b0;
        redirect_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        seed(RESET_PC);
    endtask

    // ---------------- stimulus ----------------
    int            reads;
    int            pops_before;
    int            pops_rand;
    logic          hold_pending;
    logic          redir_prev;
    logic [DW-1:0] held_pc;
    logic [DW-1:0] held_instr;

    initial begin
        rst_i         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        for (int k = 0; k < 4096; k++) mem[k] = 32'h1000 + DW'(k);
        seed(RESET_PC);
        repeat (2) @(negedge clk_i);

        // Reset state
        #1;
        check("rst_valid", DW'(instr_valid_o), 32'd0);
        check("rst_re", DW'(imem_re_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);

        // 1: fill and stream with ready high
        @(negedge clk_i);
        rst_i = 1'b1;
        instr_ready_i = 1'b1;
        seed(RESET_PC);
        #1;
        check("t1_re_c0", DW'(imem_re_o), 32'd1);
        check("t1_addr_c0", DW'(imem_raddr_o), 32'd0);
        check("t1_valid_c0", DW'(instr_valid_o), 32'd0);
        step();
        #1;
        check("t1_re_c1", DW'(imem_re_o), 32'd1);
        check("t1_addr_c1", DW'(imem_raddr_o), 32'd1);
        check("t1_valid_c1", DW'(instr_valid_o), 32'd0);
        step();
        #1;
        check("t1_valid_c2", DW'(instr_valid_o), 32'd1);
        check("t1_pc_c2", pc_o, 32'd0);
        check("t1_instr_c2", instr_o, 32'h1000);
        for (int i = 1; i <= 3; i++) begin
            step();
            #1;
            check("t1_valid_seq", DW'(instr_valid_o), 32'd1);
            check("t1_pc_seq", pc_o, DW'(4 * i));
        end
        step();

        // 2: ready low from reset, then drain without gaps
        instr_ready_i = 1'b0;
        do_reset();
        reads = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (imem_re_o) reads++;
            step();
        end
        check("t2_reads", DW'(reads), 32'd2);
        #1;
        check("t2_re_idle", DW'(imem_re_o), 32'd0);
        check("t2_valid", DW'(instr_valid_o), 32'd1);
        check("t2_hold_instr", instr_o, 32'h1000);
        check("t2_hold_pc", pc_o, 32'd0);
        instr_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t2_drain_valid", DW'(instr_valid_o), 32'd1);
            step();
        end

        // 3: redirect with one buffered entry and one read in flight
        instr_ready_i = 1'b0;
        do_reset();
        step();
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        #1;
        check("t3_re_in_redirect", DW'(imem_re_o), 32'd0);
        step();
        redirect_i = 1'b0;
        #1;
        check("t3_valid_after", DW'(instr_valid_o), 32'd0);
        check("t3_re_after", DW'(imem_re_o), 32'd1);
        check("t3_addr_after", DW'(imem_raddr_o), 32'h40);
        instr_ready_i = 1'b1;
        wait_valid("t3_wait_valid", 10);
        check("t3_first_pc", pc_o, 32'h100);
        repeat (3) step();

        // 4: misaligned target, then the wrap boundary
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        step();
        redirect_i = 1'b0;
        #1;
        check("t4_mis_addr", DW'(imem_raddr_o), 32'h40);
        wait_valid("t4_mis_wait", 10);
        check("t4_mis_pc", pc_o, 32'h100);
        repeat (2) step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        #1;
        check("t4_wrap_addr0", DW'(imem_raddr_o), 32'hFFF);
        step();
        #1;
        check("t4_wrap_addr1", DW'(imem_raddr_o), 32'h000);
        wait_valid("t4_wrap_wait", 10);
        check("t4_wrap_pc0", pc_o, 32'hFFFF_FFFC);
        step();
        #1;
        check("t4_wrap_pc1", pc_o, 32'h0000_0000);
        repeat (2) step();

        // 5: redirect and pop in the same cycle
        wait_valid("t5_wait_head", 10);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0300;
        pops_before   = n_pops;
        step();
        redirect_i = 1'b0;
        check("t5_one_handshake", DW'(n_pops - pops_before), 32'd1);
        #1;
        check("t5_empty_after", DW'(instr_valid_o), 32'd0);
        wait_valid("t5_wait_new", 10);
        check("t5_first_pc", pc_o, 32'h300);
        repeat (2) step();

        // 6: asynchronous reset mid-cycle with the FIFO full
        instr_ready_i = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        step();
        redirect_i = 1'b0;
        repeat (5) step();
        #1;
        check("t6_full_valid", DW'(instr_valid_o), 32'd1);
        check("t6_full_pc", pc_o, 32'h200);
        #2;
        rst_i = 1'b0;
        #1;
        check("t6_rst_valid", DW'(instr_valid_o), 32'd0);
        check("t6_rst_re", DW'(imem_re_o), 32'd0);
        check("t6_rst_instr", instr_o, 32'd0);
        check("t6_rst_pc", pc_o, 32'd0);
        @(negedge clk_i);
        step();
        rst_i = 1'b1;
        seed(RESET_PC);
        #1;
        check("t6_restart_re", DW'(imem_re_o), 32'd1);
        check("t6_restart_addr", DW'(imem_raddr_o), DW'(RESET_PC[AW+1:2]));
        instr_ready_i = 1'b1;
        wait_valid("t6_wait", 10);
        check("t6_restart_pc", pc_o, RESET_PC);
        repeat (3) step();

        // Randomized traffic against a fresh random imem image
        rst_i = 1'b0;
        for (int k = 0; k < 4096; k++) mem[k] = $urandom;
        step();
        step();
        rst_i = 1'b1;
        seed(RESET_PC);
        hold_pending = 1'b0;
        redir_prev   = 1'b0;
        pops_before  = n_pops;
        for (int i = 0; i < 600; i++) begin
            instr_ready_i = ($urandom_range(0, 3) != 0);
            redirect_i    = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0:       redirect_pc_i = $urandom;
                1:       redirect_pc_i = 32'hFFFF_FFF0 + DW'($urandom_range(0, 15));
                default: redirect_pc_i = DW'($urandom_range(0, 16383));
            endcase
            #1;
            if (redir_prev) check("rand_flush", DW'(instr_valid_o), 32'd0);
            if (hold_pending) begin
                check("rand_hold_valid", DW'(instr_valid_o), 32'd1);
                check("rand_hold_pc", pc_o, held_pc);
                check("rand_hold_instr", instr_o, held_instr);
            end
            hold_pending = instr_valid_o && !instr_ready_i && !redirect_i;
            redir_prev   = redirect_i;
            held_pc      = pc_o;
            held_instr   = instr_o;
            step();
        end
        redirect_i    = 1'b0;
        instr_ready_i = 1'b1;
        repeat (6) step();
        pops_rand = n_pops - pops_before;
        check("rand_progress", DW'(pops_rand >= 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
